// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared types and sizing for the iterative integer divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; only two's-complement operands with the MSB set are negated.
  function automatic logic [DIV_WIDTH-1:0] op_mag(input logic [DIV_WIDTH-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift-subtract iteration. The dividend is held in
//               the quotient register and shifted out MSB-first into the
//               partial remainder while quotient bits shift in at the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic [DIV_WIDTH-1:0] i_quo,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic [DIV_WIDTH-1:0] o_quo
);

  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH:0]   w_sub;
  logic                 w_ge;

  // Shift next dividend bit in, trial-subtract, keep the difference only when it is non-negative.
  always_comb begin
    w_shift = {i_rem, i_quo[DIV_WIDTH-1]};
    w_ge    = (w_shift >= {2'b00, i_div});
    w_sub   = w_shift[DIV_WIDTH:0] - {1'b0, i_div};
    o_rem   = w_ge ? w_sub : w_shift[DIV_WIDTH:0];
    o_quo   = {i_quo[DIV_WIDTH-2:0], w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle DIV/DIVU unit for the E stage. One quotient bit per
//               cycle; stalls E while busy and presents hi (remainder) and lo
//               (quotient) once complete until the instruction leaves E.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startE,
  input  logic                 is_signedE,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  input  logic                 cancel,
  input  logic                 hold,
  output logic                 div_stall,
  output logic                 result_valid,
  output logic [DIV_WIDTH-1:0] hi,
  output logic [DIV_WIDTH-1:0] lo
);

  div_state_e           r_state;
  div_state_e           w_state_next;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DIV_WIDTH-1:0] r_quo;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic                 r_qneg;
  logic                 r_rneg;
  logic [DIV_WIDTH-1:0] r_hi;
  logic [DIV_WIDTH-1:0] r_lo;

  logic [DIV_WIDTH:0]   w_rem_next;
  logic [DIV_WIDTH-1:0] w_quo_next;
  logic                 w_last;
  logic                 w_div_stall;
  logic                 w_result_valid;
  logic [DIV_WIDTH-1:0] w_lo_fix;
  logic [DIV_WIDTH-1:0] w_hi_fix;

  div_step u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_divisor),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  // Final step detection and sign correction of the result that step produces.
  always_comb begin
    w_last   = (r_cnt == DIV_CNT_W'(DIV_WIDTH - 1));
    w_lo_fix = r_qneg ? (~w_quo_next + 1'b1) : w_quo_next;
    w_hi_fix = r_rneg ? (~w_rem_next[DIV_WIDTH-1:0] + 1'b1) : w_rem_next[DIV_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; cancel always returns to IDLE.
  always_comb begin
    w_state_next   = r_state;
    w_div_stall    = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (startE && !cancel) begin
          w_state_next = S_BUSY;
          w_div_stall  = 1'b1;
        end
      end
      S_BUSY: begin
        if (cancel) begin
          w_state_next = S_IDLE;
        end else begin
          w_div_stall = 1'b1;
          if (w_last) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_result_valid = 1'b1;
        if (cancel || !hold) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result commit; hi/lo move only on the last BUSY step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startE && !cancel) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= op_mag(a, is_signedE);
            r_divisor <= op_mag(b, is_signedE);
            r_qneg    <= (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]) & is_signedE;
            r_rneg    <= a[DIV_WIDTH-1] & is_signedE;
          end
        end
        S_BUSY: begin
          if (!cancel) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_lo <= w_lo_fix;
              r_hi <= w_hi_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div_stall    = w_div_stall;
  assign result_valid = w_result_valid;
  assign hi           = r_hi;
  assign lo           = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        startE;
  logic        is_signedE;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hold;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .startE       (startE),
    .is_signedE   (is_signedE),
    .a            (a),
    .b            (b),
    .cancel       (cancel),
    .hold         (hold),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and follow it until div_stall drops; operands are scrambled
  // while busy. Leaves the bench in the DONE cycle with startE still asserted.
  task automatic issue_div(input string tag, input logic sgn,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] elo, input logic [31:0] ehi);
    int n;
    startE = 1'b1; is_signedE = sgn; a = va; b = vb;
    #1;
    n = 0;
    while (div_stall && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      a = $urandom; b = $urandom; is_signedE = ~sgn;
      #1;
    end
    check_eq({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check_eq({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check_eq({tag, "_lo"}, lo, elo);
    check_eq({tag, "_hi"}, hi, ehi);
    exp_lo = elo;
    exp_hi = ehi;
  endtask

  // Let the finished instruction leave E and confirm the unit is idle again.
  task automatic retire(input string tag);
    tick();
    startE = 1'b0;
    #1;
    check_eq({tag, "_idle_valid"}, {31'd0, result_valid}, 32'd0);
    check_eq({tag, "_idle_stall"}, {31'd0, div_stall}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; startE = 1'b0; is_signedE = 1'b0; a = '0; b = '0;
    cancel = 1'b0; hold = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tick(); tick();
    check_eq("rst_stall", {31'd0, div_stall}, 32'd0);
    check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    issue_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    retire("divu_100_7");
    issue_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    retire("div_m7_2");
    issue_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    retire("div_min_m1");
    issue_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    retire("divu_5_0");
    issue_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
    retire("div_m5_0");
    issue_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
    retire("divu_big");
    issue_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

    // Held in DONE with startE still present: no restart, results stable.
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      a = $urandom; b = $urandom;
      #1;
      check_eq("hold_stall", {31'd0, div_stall}, 32'd0);
      check_eq("hold_valid", {31'd0, result_valid}, 32'd1);
      check_eq("hold_lo", lo, exp_lo);
      check_eq("hold_hi", hi, exp_hi);
    end
    hold = 1'b0;
    retire("hold_release");

    // Cancel in BUSY cycle 10 (start issued in cycle 0).
    startE = 1'b1; is_signedE = 1'b0; a = 32'd1000; b = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    startE = 1'b0; cancel = 1'b1;
    #1;
    check_eq("cancel_stall_c10", {31'd0, div_stall}, 32'd0);
    tick();
    cancel = 1'b0;
    #1;
    check_eq("cancel_stall_c11", {31'd0, div_stall}, 32'd0);
    check_eq("cancel_valid", {31'd0, result_valid}, 32'd0);
    check_eq("cancel_lo_kept", lo, exp_lo);
    check_eq("cancel_hi_kept", hi, exp_hi);
    issue_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    retire("divu_9_3");

    // Reset in BUSY cycle 20.
    startE = 1'b1; is_signedE = 1'b0; a = 32'd12345; b = 32'd11;
    for (int i = 0; i < 20; i++) tick();
    startE = 1'b0; rst = 1'b1; cancel = 1'b1; hold = 1'b1;
    tick();
    rst = 1'b0; cancel = 1'b0; hold = 1'b0;
    #1;
    check_eq("midrst_stall", {31'd0, div_stall}, 32'd0);
    check_eq("midrst_valid", {31'd0, result_valid}, 32'd0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    issue_div("post_rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    retire("post_rst_100_7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
